// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 host-side init/INTA controller.
// The optional EOI states are always encoded here; only the controller decides whether to reach them.
package pic_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_UNINIT   = 4'd0;
  localparam state_t S_W_ICW1   = 4'd1;
  localparam state_t S_W_ICW2   = 4'd2;
  localparam state_t S_W_ICW3   = 4'd3;
  localparam state_t S_W_ICW4   = 4'd4;
  localparam state_t S_W_OCW1   = 4'd5;
  localparam state_t S_READY    = 4'd6;
  localparam state_t S_INTA1    = 4'd7;
  localparam state_t S_GAP      = 4'd8;
  localparam state_t S_INTA2    = 4'd9;
  localparam state_t S_VEC      = 4'd10;
  localparam state_t S_ISR_WAIT = 4'd11;
  localparam state_t S_W_EOI    = 4'd12;

  localparam logic       A0_CMD     = 1'b0;
  localparam logic       A0_DATA    = 1'b1;
  localparam logic [7:0] OCW2_NSEOI = 8'h20;

  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW4_AEOI = 1;

  typedef struct packed {
    logic [7:0] icw1;
    logic [7:0] icw2;
    logic [7:0] icw3;
    logic [7:0] icw4;
    logic [7:0] mask;
  } cfg_t;

  function automatic logic is_write(input state_t s);
    return (s == S_W_ICW1) || (s == S_W_ICW2) || (s == S_W_ICW3) ||
           (s == S_W_ICW4) || (s == S_W_OCW1) || (s == S_W_EOI);
  endfunction

endpackage

// File: rtl/pic_strobe_gen.sv
// Down-counting pulse timer shared by the write and INTA strobes.
// Loaded with a length on state entry; 'last' marks the final counted cycle.
module pic_strobe_gen #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         active,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign active = (cnt != '0);
  assign last   = (cnt == W'(1));

endmodule

// File: rtl/pic_host_ack_ctrl.sv
// CPU-side 8259 driver: ICW/OCW1 init sequence, two-pulse INTA, vector capture.
// Optional PIC_HOST_EOI_EN adds isr_done and a non-specific EOI write after each vector.
module pic_host_ack_ctrl
  import pic_pkg::*;
#(
  parameter int unsigned WR_LOW   = 2,
  parameter int unsigned INTA_LOW = 2,
  parameter int unsigned INTA_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_start,
  input  logic [7:0] cfg_icw1,
  input  logic [7:0] cfg_icw2,
  input  logic [7:0] cfg_icw3,
  input  logic [7:0] cfg_icw4,
  input  logic [7:0] cfg_mask,
`ifdef PIC_HOST_EOI_EN
  input  logic       isr_done,
`endif
  input  logic       int_i,
  input  logic [7:0] pic_din,
  output logic [7:0] pic_dout,
  output logic       pic_a0,
  output logic       pic_wr_n,
  output logic       inta_n,
  output logic [7:0] vec_o,
  output logic       vec_valid,
  output logic       ready,
  output logic       busy
);

  localparam int unsigned CW = 8;

  state_t          state, state_nxt;
  cfg_t            cfg;
  logic            start_ok;
  logic            tmr_load, tmr_active, tmr_last;
  logic [CW-1:0]   tmr_len;

  assign start_ok = cfg_start && ((state == S_UNINIT) || (state == S_READY));

  always_comb begin
    state_nxt = state;
    case (state)
      S_UNINIT: if (start_ok) state_nxt = S_W_ICW1;
      S_READY: begin
        if (start_ok)   state_nxt = S_W_ICW1;
        else if (int_i) state_nxt = S_INTA1;
      end
      S_W_ICW1: if (tmr_last) state_nxt = S_W_ICW2;
      S_W_ICW2: begin
        if (tmr_last) begin
          if (!cfg.icw1[ICW1_SNGL])    state_nxt = S_W_ICW3;
          else if (cfg.icw1[ICW1_IC4]) state_nxt = S_W_ICW4;
          else                         state_nxt = S_W_OCW1;
        end
      end
      S_W_ICW3: if (tmr_last) state_nxt = cfg.icw1[ICW1_IC4] ? S_W_ICW4 : S_W_OCW1;
      S_W_ICW4: if (tmr_last) state_nxt = S_W_OCW1;
      S_W_OCW1: if (tmr_last) state_nxt = S_READY;
      S_INTA1:  if (tmr_last) state_nxt = S_GAP;
      S_GAP:    if (tmr_last) state_nxt = S_INTA2;
      S_INTA2:  if (tmr_last) state_nxt = S_VEC;
`ifdef PIC_HOST_EOI_EN
      S_VEC: state_nxt = (cfg.icw4[ICW4_AEOI] && cfg.icw1[ICW1_IC4]) ? S_READY : S_ISR_WAIT;
      S_ISR_WAIT: if (isr_done) state_nxt = S_W_EOI;
      S_W_EOI:    if (tmr_last) state_nxt = S_READY;
`else
      S_VEC: state_nxt = S_READY;
`endif
      default: state_nxt = S_UNINIT;
    endcase
  end

  // Write states run WR_LOW low cycles plus one hold cycle, so the timer spans WR_LOW+1.
  always_comb begin
    tmr_len = '0;
    if (is_write(state_nxt))                            tmr_len = CW'(WR_LOW + 1);
    else if (state_nxt == S_GAP)                        tmr_len = CW'(INTA_GAP);
    else if (state_nxt == S_INTA1 || state_nxt == S_INTA2) tmr_len = CW'(INTA_LOW);
  end

  assign tmr_load = (state_nxt != state);

  pic_strobe_gen #(.W(CW)) u_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .len    (tmr_len),
    .active (tmr_active),
    .last   (tmr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_UNINIT;
      cfg   <= '0;
      vec_o <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) cfg <= '{icw1: cfg_icw1, icw2: cfg_icw2, icw3: cfg_icw3,
                             icw4: cfg_icw4, mask: cfg_mask};
      if (state == S_INTA2 && tmr_last) vec_o <= pic_din;
    end
  end

  always_comb begin
    pic_a0   = A0_CMD;
    pic_dout = '0;
    case (state)
      S_W_ICW1: begin pic_a0 = A0_CMD;  pic_dout = cfg.icw1;   end
      S_W_ICW2: begin pic_a0 = A0_DATA; pic_dout = cfg.icw2;   end
      S_W_ICW3: begin pic_a0 = A0_DATA; pic_dout = cfg.icw3;   end
      S_W_ICW4: begin pic_a0 = A0_DATA; pic_dout = cfg.icw4;   end
      S_W_OCW1: begin pic_a0 = A0_DATA; pic_dout = cfg.mask;   end
      S_W_EOI:  begin pic_a0 = A0_CMD;  pic_dout = OCW2_NSEOI; end
      default: ;
    endcase
  end

  assign pic_wr_n  = !(is_write(state) && tmr_active && !tmr_last);
  assign inta_n    = !(((state == S_INTA1) || (state == S_INTA2)) && tmr_active);
  assign vec_valid = (state == S_VEC);
  assign ready     = (state == S_READY);
  assign busy      = (state != S_UNINIT) && (state != S_READY);

endmodule

// File: tb/tb_pic_host_ack_ctrl.sv
// Scoreboard bench for pic_host_ack_ctrl: expected bus events queued by stimulus,
// popped and compared by a bus monitor. Define PIC_HOST_EOI_EN to cover the EOI option.
module tb_pic_host_ack_ctrl;

  localparam int unsigned WR_LOW   = 2;
  localparam int unsigned INTA_LOW = 3;
  localparam int unsigned INTA_GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_start = 1'b0;
  logic [7:0] cfg_icw1 = '0, cfg_icw2 = '0, cfg_icw3 = '0, cfg_icw4 = '0, cfg_mask = '0;
  logic       int_i = 1'b0;
  logic [7:0] pic_din = '0;
  logic [7:0] pic_dout, vec_o;
  logic       pic_a0, pic_wr_n, inta_n, vec_valid, ready, busy;
`ifdef PIC_HOST_EOI_EN
  logic       isr_done = 1'b0;
  logic [7:0] cur_icw1 = '0, cur_icw4 = '0;
`endif

  always #5 clk = ~clk;

  pic_host_ack_ctrl #(.WR_LOW(WR_LOW), .INTA_LOW(INTA_LOW), .INTA_GAP(INTA_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_icw1(cfg_icw1), .cfg_icw2(cfg_icw2), .cfg_icw3(cfg_icw3),
    .cfg_icw4(cfg_icw4), .cfg_mask(cfg_mask),
`ifdef PIC_HOST_EOI_EN
    .isr_done(isr_done),
`endif
    .int_i(int_i), .pic_din(pic_din), .pic_dout(pic_dout), .pic_a0(pic_a0),
    .pic_wr_n(pic_wr_n), .inta_n(inta_n), .vec_o(vec_o), .vec_valid(vec_valid),
    .ready(ready), .busy(busy)
  );

  // kind 0 = register write (a0, data, low cycles, hold ok); kind 1 = vector (vec_valid, vec, pulse1, gap, pulse2)
  typedef struct {
    int kind; int a0; int data; int l1; int l2; int l3;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void cmp_ev(input ev_t got);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: actual kind=%0d a0=%0d data=0x%0h l1=%0d l2=%0d l3=%0d, required none (t=%0t)",
               got.kind, got.a0, got.data, got.l1, got.l2, got.l3, $time);
      return;
    end
    e = exp_q.pop_front();
    if (got != e) begin
      n_fail++;
      $display("FAIL bus_event: actual kind=%0d a0=%0d data=0x%0h l1=%0d l2=%0d l3=%0d, required kind=%0d a0=%0d data=0x%0h l1=%0d l2=%0d l3=%0d (t=%0t)",
               got.kind, got.a0, got.data, got.l1, got.l2, got.l3,
               e.kind, e.a0, e.data, e.l1, e.l2, e.l3, $time);
    end
  endfunction

  function automatic void push_wr(input int a0, input logic [7:0] d);
    exp_q.push_back('{0, a0, int'(d), int'(WR_LOW), 1, 0});
  endfunction

  function automatic void push_vec(input logic [7:0] v);
    exp_q.push_back('{1, 1, int'(v), int'(INTA_LOW), int'(INTA_GAP), int'(INTA_LOW)});
  endfunction

  // Bus monitor: reconstructs write transactions and INTA sequences from the pins.
  always @(negedge clk) begin : monitor
    static logic       wprev = 1'b1;
    static int         wlen = 0, ph = 0, c1 = 0, g = 0, c2 = 0;
    static logic       cap_a0 = 1'b0, wbad = 1'b0, pend_vv = 1'b0, fin;
    static logic [7:0] cap_d = '0;
    ev_t got;
    if (!rst_n) begin
      wprev = 1'b1; ph = 0; pend_vv = 1'b0;
    end else begin
      fin = 1'b0;
      if (pic_wr_n === 1'b0 || inta_n === 1'b0)
        check("strobe_overlap", {31'd0, pic_wr_n | inta_n}, 32'd1);
      if (pic_wr_n === 1'b0) begin
        if (wprev) begin
          wlen = 1; cap_a0 = pic_a0; cap_d = pic_dout; wbad = 1'b0;
        end else begin
          wlen++;
          if (pic_a0 !== cap_a0 || pic_dout !== cap_d) wbad = 1'b1;
        end
      end else if (!wprev) begin
        got = '{0, int'(cap_a0), int'(cap_d), wlen,
                (!wbad && pic_a0 === cap_a0 && pic_dout === cap_d) ? 1 : 0, 0};
        cmp_ev(got);
      end
      wprev = (pic_wr_n !== 1'b0);
      case (ph)
        0: if (inta_n === 1'b0) begin ph = 1; c1 = 1; end
        1: if (inta_n === 1'b0) c1++; else begin ph = 2; g = 1; end
        2: if (inta_n !== 1'b0) g++; else begin ph = 3; c2 = 1; end
        default: begin
          if (inta_n === 1'b0) c2++;
          else begin
            got = '{1, int'(vec_valid === 1'b1), int'(vec_o), c1, g, c2};
            cmp_ev(got);
            ph = 0; fin = 1'b1;
          end
        end
      endcase
      if (pend_vv) begin
        check("vec_valid_one_cycle", {31'd0, vec_valid}, 32'd0);
        pend_vv = 1'b0;
      end else if (!fin && vec_valid === 1'b1) begin
        check("stray_vec_valid", {31'd0, vec_valid}, 32'd0);
      end
      if (fin) pend_vv = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_init(input logic [7:0] i1, i2, i3, i4, m, input bit with_int);
    int nw, cyc;
    push_wr(0, i1); push_wr(1, i2); nw = 2;
    if (!i1[1]) begin push_wr(1, i3); nw++; end
    if (i1[0])  begin push_wr(1, i4); nw++; end
    push_wr(1, m); nw++;
`ifdef PIC_HOST_EOI_EN
    cur_icw1 = i1; cur_icw4 = i4;
`endif
    cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw3 = i3; cfg_icw4 = i4; cfg_mask = m;
    cfg_start = 1'b1; int_i = with_int;
    tick();
    cfg_start = 1'b0; int_i = 1'b0;
    cfg_icw1 = 8'($urandom); cfg_icw2 = 8'($urandom); cfg_icw3 = 8'($urandom);
    cfg_icw4 = 8'($urandom); cfg_mask = 8'($urandom);
    cyc = 1;
    check("init_busy", {30'd0, ready, busy}, 32'd1);
    while (!ready && cyc < 300) begin
      cfg_start = (cyc == 2);
      tick(); cyc++;
    end
    cfg_start = 1'b0;
    check("init_ready", {31'd0, ready}, 32'd1);
    check("init_cycles", cyc, nw * (WR_LOW + 1) + 1);
    check("ready_not_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_int(input logic [7:0] v, input bit hold);
    int cyc;
    push_vec(v);
    int_i = 1'b1; pic_din = ~v;
    tick(); cyc = 1;
    check("inta_latency", {31'd0, inta_n}, 32'd0);
    check("inta_busy", {30'd0, ready, busy}, 32'd1);
    while (vec_valid !== 1'b1 && cyc < 100) begin
      if (!hold) int_i = 1'b0;
      pic_din = (cyc >= INTA_LOW + INTA_GAP + 1 && cyc <= 2 * INTA_LOW + INTA_GAP)
                ? v : v ^ 8'($urandom_range(1, 255));
      tick(); cyc++;
    end
    int_i = 1'b0;
    check("vec_latency", cyc, 2 * INTA_LOW + INTA_GAP + 1);
    check("vec_o", {24'd0, vec_o}, {24'd0, v});
`ifdef PIC_HOST_EOI_EN
    if (cur_icw4[1] && cur_icw1[0]) begin
      tick();
      check("aeoi_ready", {31'd0, ready}, 32'd1);
    end else begin
      tick();
      check("isr_wait_busy", {30'd0, ready, busy}, 32'd1);
      repeat ($urandom_range(0, 3)) tick();
      push_wr(0, 8'h20);
      isr_done = 1'b1; tick(); isr_done = 1'b0;
      cyc = 1;
      while (!ready && cyc < 50) begin tick(); cyc++; end
      check("eoi_ready_cycles", cyc, WR_LOW + 2);
    end
`else
    tick();
    check("back_to_ready", {31'd0, ready}, 32'd1);
`endif
  endtask

  task automatic do_reset_mid_inta();
    int cyc;
    int_i = 1'b1; pic_din = 8'($urandom);
    tick(); int_i = 1'b0; cyc = 1;
    while (cyc < INTA_LOW + INTA_GAP + 1) begin tick(); cyc++; end
    check("inta2_low", {31'd0, inta_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_inta_n", {31'd0, inta_n}, 32'd1);
    check("rst_wr_n", {31'd0, pic_wr_n}, 32'd1);
    check("rst_ready_busy", {30'd0, ready, busy}, 32'd0);
    check("rst_vec", {23'd0, vec_valid, vec_o}, 32'd0);
    check("rst_bus", {23'd0, pic_a0, pic_dout}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    int_i = 1'b1;
    repeat (4) tick();
    check("uninit_ignores_int", {30'd0, inta_n, ready}, 32'd2);
    int_i = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] r1, r4;
    #1 rst_n = 1'b0;
    #1;
    check("reset_strobes", {30'd0, pic_wr_n, inta_n}, 32'd3);
    check("reset_bus", {23'd0, pic_a0, pic_dout}, 32'd0);
    check("reset_vec", {23'd0, vec_valid, vec_o}, 32'd0);
    check("reset_status", {30'd0, ready, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("uninit_status", {30'd0, ready, busy}, 32'd0);

    do_init(8'h13, 8'h40, 8'h5A, 8'h01, 8'hF0, 1'b1);
    do_int(8'h43, 1'b1);
    do_int(8'h43, 1'b0);
    do_init(8'h10, 8'h48, 8'h04, 8'h01, 8'hFF, 1'b0);
    do_int(8'h4C, 1'b0);
    do_init(8'h11, 8'h50, 8'h02, 8'h01, 8'h0F, 1'b0);
    do_init(8'h12, 8'h58, 8'h33, 8'h01, 8'hA5, 1'b1);
    do_int(8'h5B, 1'b1);
    do_reset_mid_inta();
    do_init(8'h13, 8'h40, 8'h00, 8'h01, 8'hF0, 1'b0);
    do_int(8'h41, 1'b0);
    do_init(8'h13, 8'h40, 8'h00, 8'h03, 8'hF0, 1'b0);
    do_int(8'h42, 1'b1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r1 = 8'h10 | 8'($urandom_range(0, 3));
        r4 = 8'($urandom);
        do_init(r1, 8'($urandom), 8'($urandom), r4, 8'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        do_int(8'($urandom), 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
